// File: rtl/musa_pkg.sv
// Shared MUSA front-end definitions: fetch FSM encoding, default reset PC,
// and the word-address increment.
package musa_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SQUASH = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned WORD_INC         = 1;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register for a fetched {instruction, pc, pc_1} that
// arrived while decode was stalled.
module if_skid_buffer
  import musa_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_load,
  input  logic                  i_drain,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic [ADDR_WIDTH-1:0] i_pc_1,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [ADDR_WIDTH-1:0] o_pc_1
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_pc_1;

  // Flush wins over load so a redirect never leaves a wrong-path entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_pc_1  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_pc_1  <= i_pc_1;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pc_1  = r_pc_1;

endmodule

// File: rtl/if_fetch_stage.sv
// MUSA instruction-fetch stage: owns the fetch PC, issues word requests to
// instruction memory and hands {instruction, pc, pc_1} to decode.
module if_fetch_stage
  import musa_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  input  logic                  redirect,
  input  logic                  stall,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_1,
  output logic                  valid,
  output fetch_state_e          dbg_state
);

  // Handshakes: a memory transfer happens on a cycle with imem_req && imem_ack,
  // and req/addr hold until then; decode takes the output on valid && !stall.
  fetch_state_e          r_state;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_squash_addr;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_pc_1;

  logic                  w_req;
  logic                  w_ack;
  logic                  w_out_free;
  logic [ADDR_WIDTH-1:0] w_fetch_pc_1;
  logic                  w_skid_load;
  logic                  w_skid_drain;
  logic                  w_skid_valid;
  logic [DATA_WIDTH-1:0] w_skid_instr;
  logic [ADDR_WIDTH-1:0] w_skid_pc;
  logic [ADDR_WIDTH-1:0] w_skid_pc_1;

  assign w_req        = !reset && (r_state != ST_HOLD);
  assign w_ack        = imem_ack && w_req;
  assign w_out_free   = !r_valid || !stall;
  assign w_fetch_pc_1 = r_fetch_pc + ADDR_WIDTH'(WORD_INC);
  assign w_skid_load  = (r_state == ST_FETCH) && w_ack && !w_out_free && !redirect;
  assign w_skid_drain = (r_state == ST_HOLD) && !stall && !redirect;

  if_skid_buffer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .i_clk   (clock),
    .i_reset (reset),
    .i_flush (redirect),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_instr (imem_rdata),
    .i_pc    (r_fetch_pc),
    .i_pc_1  (w_fetch_pc_1),
    .o_valid (w_skid_valid),
    .o_instr (w_skid_instr),
    .o_pc    (w_skid_pc),
    .o_pc_1  (w_skid_pc_1)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_FETCH;
      r_fetch_pc    <= RESET_PC;
      r_squash_addr <= '0;
      r_valid       <= 1'b0;
      r_instr       <= '0;
      r_pc          <= '0;
      r_pc_1        <= '0;
    end else if (redirect) begin
      r_fetch_pc <= next_pc;
      r_valid    <= 1'b0;
      // An unacknowledged request must still complete before the new path starts.
      case (r_state)
        ST_FETCH: begin
          if (!w_ack) begin
            r_state       <= ST_SQUASH;
            r_squash_addr <= r_fetch_pc;
          end
        end
        ST_SQUASH: if (w_ack) r_state <= ST_FETCH;
        default:   r_state <= ST_FETCH;
      endcase
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_ack) begin
            r_fetch_pc <= w_fetch_pc_1;
            if (w_out_free) begin
              r_valid <= 1'b1;
              r_instr <= imem_rdata;
              r_pc    <= r_fetch_pc;
              r_pc_1  <= w_fetch_pc_1;
            end else begin
              r_state <= ST_HOLD;
            end
          end else if (!stall) begin
            r_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall && w_skid_valid) begin
            r_valid <= 1'b1;
            r_instr <= w_skid_instr;
            r_pc    <= w_skid_pc;
            r_pc_1  <= w_skid_pc_1;
            r_state <= ST_FETCH;
          end
        end
        ST_SQUASH: if (w_ack) r_state <= ST_FETCH;
        default:   r_state <= ST_FETCH;
      endcase
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = (r_state == ST_SQUASH) ? r_squash_addr : r_fetch_pc;
  assign instruction = r_instr;
  assign pc          = r_pc;
  assign pc_1        = r_pc_1;
  assign valid       = r_valid;
  assign dbg_state   = r_state;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch front end of the MUSA core, on the consuming side of the execute stage's next-PC output. It holds the fetch PC and issues word-addressed requests to instruction memory over a req/ack handshake. It presents {instruction, pc, pc_1, valid} to decode, honours decode stalls, and takes redirects (jump/branch/jr/stack return) from execute, squashing wrong-path fetches.

Parameters:
ADDR_WIDTH, 32, PC and memory address width (word addressing)
DATA_WIDTH, 32, instruction width
RESET_PC, 0, fetch address after reset

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
next_pc  in  ADDR_WIDTH  redirect target from execute
redirect  in  1  one-cycle pulse: load next_pc, flush younger fetches
stall  in  1  decode cannot accept output this cycle
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  ADDR_WIDTH  fetch word address, stable while imem_req=1
imem_ack  in  1  memory response valid; may assert in same cycle as imem_req
imem_rdata  in  DATA_WIDTH  instruction word, valid with imem_ack
instruction  out  DATA_WIDTH  registered instruction to decode
pc  out  ADDR_WIDTH  address of instruction
pc_1  out  ADDR_WIDTH  pc + 1
valid  out  1  output triple valid

Behaviour:
- Reset (synchronous, active-high): fetch_pc=RESET_PC, state=FETCH, imem_req=0 during reset cycle, valid=0, instruction=0, pc=0, pc_1=0, skid empty.
- States: FETCH, HOLD, SQUASH.
- FETCH: imem_req=1, imem_addr=fetch_pc. On imem_ack (no redirect): fetch_pc<=fetch_pc+1. Data goes to output register if free (!valid || !stall), else into one-entry skid buffer and state->HOLD.
- Output consumed when valid && !stall. Output register never changes while valid && stall (except redirect/reset).
- HOLD: imem_req=0. When output consumed, skid moves into output register next edge, skid clears, state->FETCH.
- Latency: zero-wait memory -> instruction visible the cycle after req; throughput 1 instruction/cycle. N-cycle ack -> one instruction per N+1 cycles.
- Redirect (highest priority after reset): fetch_pc<=next_pc, valid<=0, skid cleared, regardless of stall.
  - No outstanding request, or ack in the same cycle: discard ack data, state->FETCH, next imem_addr=next_pc.
  - Request outstanding without ack: state->SQUASH; imem_req stays 1, imem_addr stays old address (never drop req before ack). On ack, data discarded, state->FETCH with new fetch_pc.
  - Redirect while in SQUASH: update fetch_pc only; remain SQUASH.
- Reset mid-request: request abandoned; memory shares same reset.
- Arithmetic: pc_1 and fetch_pc increment modulo 2^ADDR_WIDTH; all-ones wraps to 0.
- imem_ack while imem_req=0 is ignored.

Decomposition:
- Shared package musa_pkg: fetch state encoding (FETCH/HOLD/SQUASH), RESET_PC default, word increment constant.
- One sub-module: if_skid_buffer (one-entry {instruction, pc, pc_1} holding register with load/drain/flush).

Test Plan:
- Reset, zero-wait memory returning rdata=addr+0x100 -> imem_addr 0,1,2,... every cycle; first valid cycle after first req: instruction=0x100, pc=0, pc_1=1; then one per cycle.
- Ack latency 3 cycles -> imem_req/imem_addr held stable 3 cycles; instructions for pc 0,1,2 delivered every 4 cycles, no duplicates.
- Zero-wait, stall high 5 cycles at pc=2 -> output holds pc=2, skid holds pc=3, imem_req=0; after release outputs pc=3 then 4, no loss or duplication.
- Redirect next_pc=0x40 with req outstanding (ack 2 cycles later) -> valid=0, old data discarded, next req addr 0x40, output pc=0x40, pc_1=0x41.
- Redirect same cycle as ack while stall=1 and skid full -> output and skid flushed, ack data dropped, next imem_addr=0x40.
- RESET_PC=0xFFFFFFFF -> first output pc=0xFFFFFFFF, pc_1=0, next imem_addr=0; reset asserted mid-wait -> imem_req=0 during reset cycle, then fetch restarts at RESET_PC.
